// File: rtl/mpq_pkg.sv
// Shared definitions for the MPQ command scheduler: opcodes, FSM states,
// command payload struct and the command legality check.
package mpq_pkg;

   localparam int unsigned CMD_W  = 3;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned VAL_W  = 8;
   localparam int unsigned SIZE_W = 8;

   typedef logic [CMD_W-1:0]  cmd_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [VAL_W-1:0]  val_t;
   typedef logic [SIZE_W-1:0] size_t;

   localparam cmd_t CMD_BUILD    = 3'd0;
   localparam cmd_t CMD_EXTRACT  = 3'd1;
   localparam cmd_t CMD_INCREASE = 3'd2;
   localparam cmd_t CMD_INSERT   = 3'd3;
   localparam cmd_t CMD_WRITE    = 3'd4;

   localparam size_t MPQ_MAX_SIZE = 8'd255;

   typedef enum logic [2:0] {
      ST_LOAD       = 3'd0,
      ST_IDLE       = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_END   = 3'd3,
      ST_HALT       = 3'd4
   } state_t;

   // Command payload as presented on the MPQ command port
   typedef struct packed {
      cmd_t cmd;
      idx_t index;
      val_t value;
   } mpq_cmd_t;

   // True when the command may be sent to an MPQ currently holding q elements
   function automatic logic cmd_legal(input cmd_t c, input idx_t i, input size_t q);
      logic ok;
      case (c)
         CMD_BUILD, CMD_WRITE: ok = 1'b1;
         CMD_EXTRACT:          ok = (q != '0);
         CMD_INCREASE:         ok = (i < q);
         CMD_INSERT:           ok = (q != MPQ_MAX_SIZE);
         default:              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping around.
//   req   : request vector
//   ptr   : highest-priority position
//   grant : one-hot winner (zero when no request)
//   valid : any request present
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic [N-1:0] rot_req;
   logic [N-1:0] rot_gnt;
   logic         found;

   // Rotate so that position ptr lands on bit 0
   assign rot_req = N'({req, req} >> ptr);

   // Fixed-priority pick on the rotated vector
   always_comb begin
      rot_gnt = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && rot_req[i]) begin
            rot_gnt[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   // Rotate the winner back into requester numbering
   assign grant = N'(({rot_gnt, rot_gnt} << ptr) >> N);
   assign valid = |req;

endmodule

// File: rtl/mpq_cmd_sched.sv
// Round-robin scheduler sharing one max-priority-queue engine among NREQ
// requesters. Tracks a shadow element count, rejects illegal commands before
// they reach the engine, and reports grant / completion / error per requester.
//   clk, rst        : clock, asynchronous active-low reset
//   req, req_*      : per-requester request level and command fields
//   gnt, ack, err   : per-requester one-cycle pulses
//   mpq_data_valid  : MPQ load strobe (counted while loading)
//   mpq_busy        : MPQ busy
//   mpq_done        : MPQ end-of-Write pulse
//   cmd_valid, cmd, index, value : MPQ command port
//   q_size          : shadow element count
//   halted          : sticky after Write completes
module mpq_cmd_sched
   import mpq_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [CMD_W*NREQ-1:0]   req_cmd,
   input  logic [IDX_W*NREQ-1:0]   req_index,
   input  logic [VAL_W*NREQ-1:0]   req_value,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         ack,
   output logic [NREQ-1:0]         err,
   input  logic                    mpq_data_valid,
   input  logic                    mpq_busy,
   input  logic                    mpq_done,
   output logic                    cmd_valid,
   output logic [CMD_W-1:0]        cmd,
   output logic [IDX_W-1:0]        index,
   output logic [VAL_W-1:0]        value,
   output logic [SIZE_W-1:0]       q_size,
   output logic                    halted
);

   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   state_t            state, state_nxt;
   logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [NREQ-1:0]   owner, owner_nxt;
   logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
   logic              done_seen, done_seen_nxt;
   mpq_cmd_t          issued, issued_nxt;
   logic [SIZE_W-1:0] q_size_nxt;
   logic              halted_nxt;
   logic [NREQ-1:0]   gnt_nxt, ack_nxt, err_nxt;
   logic              cmd_valid_nxt;

   logic [NREQ-1:0]   req_eff;
   logic [NREQ-1:0]   win_oh;
   logic              win_valid;
   logic [PTR_W-1:0]  win_idx;
   mpq_cmd_t          win_cmd;
   logic              tmo_hit;

   // A requester sees its gnt one cycle late, so mask it to avoid a double grant
   assign req_eff = req & ~gnt;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (req_eff),
      .ptr   (rr_ptr),
      .grant (win_oh),
      .valid (win_valid)
   );

   // Winner position and its command fields
   always_comb begin
      win_idx = '0;
      win_cmd = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_idx       = PTR_W'(i);
            win_cmd.cmd   = req_cmd[CMD_W*i +: CMD_W];
            win_cmd.index = req_index[IDX_W*i +: IDX_W];
            win_cmd.value = req_value[VAL_W*i +: VAL_W];
         end
      end
   end

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

   assign cmd   = issued.cmd;
   assign index = issued.index;
   assign value = issued.value;

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_LOAD;
         rr_ptr    <= '0;
         owner     <= '0;
         tmo_cnt   <= '0;
         done_seen <= 1'b0;
         issued    <= '0;
         q_size    <= '0;
         halted    <= 1'b0;
         gnt       <= '0;
         ack       <= '0;
         err       <= '0;
         cmd_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         owner     <= owner_nxt;
         tmo_cnt   <= tmo_nxt;
         done_seen <= done_seen_nxt;
         issued    <= issued_nxt;
         q_size    <= q_size_nxt;
         halted    <= halted_nxt;
         gnt       <= gnt_nxt;
         ack       <= ack_nxt;
         err       <= err_nxt;
         cmd_valid <= cmd_valid_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      owner_nxt     = owner;
      tmo_nxt       = tmo_cnt;
      done_seen_nxt = done_seen;
      issued_nxt    = issued;
      q_size_nxt    = q_size;
      halted_nxt    = halted;
      gnt_nxt       = '0;
      ack_nxt       = '0;
      err_nxt       = '0;
      cmd_valid_nxt = 1'b0;

      case (state)
         ST_LOAD: begin
            if (mpq_data_valid && (q_size != MPQ_MAX_SIZE)) begin
               q_size_nxt = q_size + SIZE_W'(1);
            end
            if (!mpq_busy) begin
               state_nxt = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (!mpq_busy && win_valid) begin
               gnt_nxt    = win_oh;
               rr_ptr_nxt = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
               if (cmd_legal(win_cmd.cmd, win_cmd.index, q_size)) begin
                  issued_nxt    = win_cmd;
                  cmd_valid_nxt = 1'b1;
                  owner_nxt     = win_oh;
                  tmo_nxt       = '0;
                  done_seen_nxt = 1'b0;
                  state_nxt     = ST_WAIT_START;
               end else begin
                  err_nxt = win_oh;
               end
            end
         end

         // The MPQ samples the strobe a cycle late, so a busy rise is required
         ST_WAIT_START: begin
            if (mpq_done) begin
               done_seen_nxt = 1'b1;
            end
            if (mpq_busy) begin
               tmo_nxt   = '0;
               state_nxt = ST_WAIT_END;
            end else if (tmo_hit) begin
               err_nxt   = owner;
               state_nxt = ST_IDLE;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end

         // Write completes only once done has been observed and busy is low
         ST_WAIT_END: begin
            if (mpq_done) begin
               done_seen_nxt = 1'b1;
            end
            if (!mpq_busy && ((issued.cmd != CMD_WRITE) || done_seen || mpq_done)) begin
               ack_nxt = owner;
               if (issued.cmd == CMD_WRITE) begin
                  halted_nxt = 1'b1;
                  state_nxt  = ST_HALT;
               end else begin
                  if (issued.cmd == CMD_INSERT) begin
                     q_size_nxt = q_size + SIZE_W'(1);
                  end else if (issued.cmd == CMD_EXTRACT) begin
                     q_size_nxt = q_size - SIZE_W'(1);
                  end
                  state_nxt = ST_IDLE;
               end
            end else if (tmo_hit) begin
               err_nxt   = owner;
               state_nxt = ST_IDLE;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end

         ST_HALT: begin
            gnt_nxt = req_eff;
            err_nxt = req_eff;
         end

         default: begin
            state_nxt = ST_LOAD;
         end
      endcase
   end

endmodule

// File: tb/tb_mpq_cmd_sched.sv
module tb_mpq_cmd_sched;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 20;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] req_cmd;
   logic [31:0] req_index;
   logic [31:0] req_value;
   logic [3:0]  gnt, ack, err;
   logic        mpq_data_valid;
   logic        mpq_busy;
   logic        mpq_done;
   logic        cmd_valid;
   logic [2:0]  cmd;
   logic [7:0]  index;
   logic [7:0]  value;
   logic [7:0]  q_size;
   logic        halted;

   logic hold_busy, stub_busy, stub_dead;
   assign mpq_busy = stub_busy | hold_busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cyc = 0;
   int last_ack_cyc = 0;

   typedef struct packed {
      logic       cv;
      logic [2:0] c;
      logic [7:0] i;
      logic [7:0] v;
      logic [3:0] g;
      logic [3:0] a;
      logic [3:0] e;
   } ev_t;

   ev_t sb[$];

   mpq_cmd_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .req_cmd        (req_cmd),
      .req_index      (req_index),
      .req_value      (req_value),
      .gnt            (gnt),
      .ack            (ack),
      .err            (err),
      .mpq_data_valid (mpq_data_valid),
      .mpq_busy       (mpq_busy),
      .mpq_done       (mpq_done),
      .cmd_valid      (cmd_valid),
      .cmd            (cmd),
      .index          (index),
      .value          (value),
      .q_size         (q_size),
      .halted         (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic ev_t mk(input logic cv, input logic [2:0] c, input logic [7:0] i,
                              input logic [7:0] v, input logic [3:0] g,
                              input logic [3:0] a, input logic [3:0] e);
      ev_t r;
      r.cv = cv; r.c = c; r.i = i; r.v = v; r.g = g; r.a = a; r.e = e;
      return r;
   endfunction

   function automatic logic [3:0] oh(input int k);
      logic [3:0] r;
      r = '0;
      r[k] = 1'b1;
      return r;
   endfunction

   task automatic exp_issue(input int k, input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
      sb.push_back(mk(1'b1, c, i, v, oh(k), 4'b0, 4'b0));
   endtask

   task automatic exp_ack(input int k);
      sb.push_back(mk(1'b0, 3'd0, 8'd0, 8'd0, 4'b0, oh(k), 4'b0));
   endtask

   task automatic exp_err(input int k);
      sb.push_back(mk(1'b0, 3'd0, 8'd0, 8'd0, 4'b0, 4'b0, oh(k)));
   endtask

   task automatic exp_rej(input logic [3:0] m);
      sb.push_back(mk(1'b0, 3'd0, 8'd0, 8'd0, m, 4'b0, m));
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_fields(input int k, input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
      req_cmd[3*k +: 3]   = c;
      req_index[8*k +: 8] = i;
      req_value[8*k +: 8] = v;
   endtask

   // Raise the requests in m and drop each one in the cycle its gnt shows
   task automatic issue_reqs(input logic [3:0] m);
      req = m;
      for (int t = 0; t < 100 && req != 4'b0; t++) begin
         @(negedge clk);
         req = req & ~gnt;
      end
      if (req != 4'b0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL grant_wait: actual pending=%b required pending=0000", req);
         req = 4'b0;
      end
   endtask

   // Wait until every expected event has been observed
   task automatic drain();
      for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: actual outstanding=%0d required outstanding=0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   // MPQ stub: busy one cycle after the strobe for three cycles; Write pulses
   // done two cycles after busy falls
   initial begin
      logic [2:0] c;
      stub_busy = 1'b0;
      mpq_done  = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (cmd_valid && !stub_dead) begin
            c = cmd;
            @(posedge clk); #1;
            stub_busy = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            stub_busy = 1'b0;
            if (c == 3'd4) begin
               repeat (2) @(posedge clk);
               #1;
               mpq_done = 1'b1;
               done_cyc = cyc;
               @(posedge clk); #1;
               mpq_done = 1'b0;
            end
         end
      end
   end

   // Monitor: every cycle with DUT activity consumes one expected event
   initial begin
      ev_t act, exp;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && (cmd_valid || gnt != 4'b0 || ack != 4'b0 || err != 4'b0)) begin
            act = mk(cmd_valid, cmd_valid ? cmd : 3'd0, cmd_valid ? index : 8'd0,
                     cmd_valid ? value : 8'd0, gnt, ack, err);
            if (ack != 4'b0) last_ack_cyc = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL event: actual cv=%0b cmd=%0d idx=%0d val=%0d gnt=%b ack=%b err=%b required no event",
                        act.cv, act.c, act.i, act.v, act.g, act.a, act.e);
            end else begin
               exp = sb.pop_front();
               if (act !== exp) begin
                  n_bad++;
                  $display("FAIL event: actual cv=%0b cmd=%0d idx=%0d val=%0d gnt=%b ack=%b err=%b required cv=%0b cmd=%0d idx=%0d val=%0d gnt=%b ack=%b err=%b",
                           act.cv, act.c, act.i, act.v, act.g, act.a, act.e,
                           exp.cv, exp.c, exp.i, exp.v, exp.g, exp.a, exp.e);
               end
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b0; req = '0; req_cmd = '0; req_index = '0; req_value = '0;
      mpq_data_valid = 1'b0; hold_busy = 1'b1; stub_dead = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({gnt, ack, err, cmd_valid, cmd, index, value, q_size, halted}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Load five elements while the MPQ is busy loading
      @(posedge clk); #1;
      mpq_data_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      mpq_data_valid = 1'b0;
      hold_busy = 1'b0;
      @(posedge clk); #1;
      check("load_q_size", 64'(q_size), 64'd5);
      @(negedge clk);

      // Build from requester 0
      set_fields(0, 3'd0, 8'd0, 8'd0);
      exp_issue(0, 3'd0, 8'd0, 8'd0);
      exp_ack(0);
      issue_reqs(4'b0001);
      drain();
      check("build_q_size", 64'(q_size), 64'd5);

      // Increase with index >= q_size rejected; pointer wraps to 0
      set_fields(3, 3'd2, 8'd7, 8'd9);
      exp_rej(4'b1000);
      issue_reqs(4'b1000);
      drain();

      // Four simultaneous inserts served in order 0..3
      for (int k = 0; k < 4; k++) begin
         set_fields(k, 3'd3, 8'd0, 8'(10 * k + 1));
         exp_issue(k, 3'd3, 8'd0, 8'(10 * k + 1));
         exp_ack(k);
      end
      issue_reqs(4'b1111);
      drain();
      check("rr_insert_q_size", 64'(q_size), 64'd9);

      // Engine never answers: err after TIMEOUT cycles, then normal service
      stub_dead = 1'b1;
      set_fields(1, 3'd0, 8'd0, 8'd0);
      exp_issue(1, 3'd0, 8'd0, 8'd0);
      exp_err(1);
      issue_reqs(4'b0010);
      n = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         n++;
         if (err[1]) break;
      end
      check("timeout_latency", 64'(n), 64'(TIMEOUT));
      drain();
      stub_dead = 1'b0;
      check("timeout_q_size", 64'(q_size), 64'd9);
      set_fields(2, 3'd3, 8'd0, 8'h77);
      exp_issue(2, 3'd3, 8'd0, 8'h77);
      exp_ack(2);
      issue_reqs(4'b0100);
      drain();
      check("post_timeout_q_size", 64'(q_size), 64'd10);

      // Reset while waiting for busy to fall
      set_fields(0, 3'd3, 8'd0, 8'h55);
      exp_issue(0, 3'd3, 8'd0, 8'h55);
      issue_reqs(4'b0001);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      hold_busy = 1'b1;
      #1;
      check("async_reset_outputs", 64'({gnt, ack, err, cmd_valid, cmd, index, value, q_size, halted}), 64'd0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_reset_q_size", 64'(q_size), 64'd0);
      hold_busy = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Extract on an empty queue rejected
      set_fields(2, 3'd1, 8'd0, 8'd0);
      exp_rej(4'b0100);
      issue_reqs(4'b0100);
      drain();
      check("empty_extract_q_size", 64'(q_size), 64'd0);

      for (int j = 0; j < 3; j++) begin
         set_fields(1, 3'd3, 8'd0, 8'(j + 1));
         exp_issue(1, 3'd3, 8'd0, 8'(j + 1));
         exp_ack(1);
         issue_reqs(4'b0010);
         drain();
      end
      check("refill_q_size", 64'(q_size), 64'd3);

      // Increase index 3 with q_size 3 rejected, opcode 6 rejected, index 2 accepted
      set_fields(3, 3'd2, 8'd3, 8'h20);
      exp_rej(4'b1000);
      issue_reqs(4'b1000);
      drain();
      set_fields(1, 3'd6, 8'd0, 8'd0);
      exp_rej(4'b0010);
      issue_reqs(4'b0010);
      drain();
      set_fields(0, 3'd2, 8'd2, 8'h40);
      exp_issue(0, 3'd2, 8'd2, 8'h40);
      exp_ack(0);
      issue_reqs(4'b0001);
      drain();
      check("increase_q_size", 64'(q_size), 64'd3);

      // Write: ack only after done, then halted
      set_fields(2, 3'd4, 8'd0, 8'd0);
      exp_issue(2, 3'd4, 8'd0, 8'd0);
      exp_ack(2);
      issue_reqs(4'b0100);
      drain();
      check("halted_after_write", 64'(halted), 64'd1);
      check("write_ack_after_done", 64'(last_ack_cyc > done_cyc), 64'd1);

      // Halted: every request gets gnt+err, no MPQ traffic
      set_fields(3, 3'd3, 8'd0, 8'd1);
      set_fields(0, 3'd3, 8'd0, 8'd2);
      exp_rej(4'b1001);
      issue_reqs(4'b1001);
      drain();
      check("halt_q_size", 64'(q_size), 64'd3);
      check("halt_sticky", 64'(halted), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
